// File: rtl/run_controller_if.sv
// Signal bundle between the TD4 board controls and the run controller:
// operator inputs and the CPU halt request go in; the execution strobe and status come out.
interface run_controller_if;
    logic       step_button;
    logic       run_switch;
    logic       fast_switch;
    logic       halt;
    logic       cpu_enable;
    logic       running;
    logic       halted;
    logic [7:0] step_count;

    modport master (
        output step_button, run_switch, fast_switch, halt,
        input  cpu_enable, running, halted, step_count
    );

    modport slave (
        input  step_button, run_switch, fast_switch, halt,
        output cpu_enable, running, halted, step_count
    );
endinterface

// File: rtl/run_controller.sv
// TD4 execution sequencer: turns a debounced step button or a free-running tick
// into single-cycle cpu_enable strobes, with a sticky HALTED state.
module run_controller #(
    parameter int DEBOUNCE   = 1_000_000,
    parameter int TICKS_SLOW = 50_000_000,
    parameter int TICKS_FAST = 5_000_000
) (
    input  logic            clock,
    input  logic            reset,
    run_controller_if.slave ctrl_io
);
    localparam int DebW  = $clog2(DEBOUNCE + 1);
    localparam int TickW = $clog2(TICKS_SLOW + 1);

    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE - 1);
    localparam logic [TickW-1:0] SlowLast = TickW'(TICKS_SLOW - 1);
    localparam logic [TickW-1:0] FastLast = TickW'(TICKS_FAST - 1);

    typedef enum logic [1:0] {
        STOPPED,
        RUNNING,
        HALTED
    } state_e;

    logic             syncMeta_q;
    logic             syncOut_q;
    logic             debLevel_q;
    logic             debPrev_q;
    logic [DebW-1:0]  debCount_q;

    state_e           state_q;
    state_e           state_d;
    logic [TickW-1:0] tickCount_q;
    logic [TickW-1:0] tickCount_d;
    logic             cpuEnable_q;
    logic             cpuEnable_d;
    logic             running_q;
    logic             halted_q;
    logic [7:0]       stepCount_q;

    logic             press;
    logic [TickW-1:0] periodLast;

    // The raw button only ever reaches the synchronizer; the debounced level flips
    // after DEBOUNCE consecutive mismatched samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
            debLevel_q <= 1'b0;
            debPrev_q  <= 1'b0;
            debCount_q <= '0;
        end else begin
            syncMeta_q <= ctrl_io.step_button;
            syncOut_q  <= syncMeta_q;
            debPrev_q  <= debLevel_q;
            if (syncOut_q == debLevel_q) begin
                debCount_q <= '0;
            end else if (debCount_q == DebLast) begin
                debLevel_q <= syncOut_q;
                debCount_q <= '0;
            end else begin
                debCount_q <= debCount_q + DebW'(1);
            end
        end
    end

    assign press      = debLevel_q & ~debPrev_q;
    assign periodLast = ctrl_io.fast_switch ? FastLast : SlowLast;

    // Halt outranks everything; the >= compare lets a switch to the fast rate
    // fire at once when the slow count is already past the fast terminal value.
    always_comb begin
        state_d     = state_q;
        tickCount_d = tickCount_q;
        cpuEnable_d = 1'b0;
        case (state_q)
            STOPPED: begin
                if (ctrl_io.halt) begin
                    state_d = HALTED;
                end else begin
                    cpuEnable_d = press;
                    if (ctrl_io.run_switch) begin
                        state_d     = RUNNING;
                        tickCount_d = '0;
                    end
                end
            end
            RUNNING: begin
                if (ctrl_io.halt) begin
                    state_d = HALTED;
                end else if (!ctrl_io.run_switch) begin
                    state_d = STOPPED;
                end else if (tickCount_q >= periodLast) begin
                    cpuEnable_d = 1'b1;
                    tickCount_d = '0;
                end else begin
                    tickCount_d = tickCount_q + TickW'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = STOPPED;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= STOPPED;
            tickCount_q <= '0;
            cpuEnable_q <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            stepCount_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            tickCount_q <= tickCount_d;
            cpuEnable_q <= cpuEnable_d;
            running_q   <= (state_d == RUNNING);
            halted_q    <= (state_d == HALTED);
            if (cpuEnable_d) begin
                stepCount_q <= stepCount_q + 8'd1;
            end
        end
    end

    assign ctrl_io.cpu_enable = cpuEnable_q;
    assign ctrl_io.running    = running_q;
    assign ctrl_io.halted     = halted_q;
    assign ctrl_io.step_count = stepCount_q;
endmodule

// File: doc/run_controller.md
# run_controller

Execution sequencer for the TD4 CPU: decides on which cycles `mother_board` may advance one instruction. It takes the raw board clock, the push button and the slide switches, and issues a single-cycle `cpu_enable` strobe. Modes are manual single-step, or free-run at one of two selectable rates. A sticky HALTED state is entered on a halt request from the CPU.

## Interface
- `DEBOUNCE`, default 1_000_000: consecutive stable cycles before the step button level is accepted.
- `TICKS_SLOW`, default 50_000_000: free-run period in cycles when `fast_switch`=0 (≥2).
- `TICKS_FAST`, default 5_000_000: free-run period in cycles when `fast_switch`=1 (≥2, ≤`TICKS_SLOW`).
- `clock` in 1: board clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `step_button` in 1: raw push button, active-high, asynchronous, bouncy.
- `run_switch` in 1: level; 1 requests free run, 0 requests stop.
- `fast_switch` in 1: level; selects `TICKS_FAST` (1) or `TICKS_SLOW` (0).
- `halt` in 1: level from the CPU; 1 stops execution.
- `cpu_enable` out 1: one-cycle strobe; CPU executes one instruction per strobe.
- `running` out 1: high in RUNNING.
- `halted` out 1: high in HALTED.
- `step_count` out 8: strobes issued since reset, mod 256.

## Operation
- Synchronizer: 2-flop synchronizer on `step_button` feeds the debouncer. Raw input is used nowhere else.
- Debouncer:
  - The counter increments while the synchronized level ≠ the debounced level, and clears otherwise.
  - The debounced level flips when the counter reaches `DEBOUNCE`-1 while still mismatched.
  - A press is a registered rising edge of the debounced level.
- FSM states: STOPPED, RUNNING, HALTED. Reset state is STOPPED.
- STOPPED:
  - A press issues exactly one `cpu_enable`; the state stays STOPPED.
  - `run_switch`=1 and `halt`=0 → RUNNING, with the tick counter cleared.
  - `halt`=1 → HALTED. This has priority over run and over a press in the same cycle; no strobe is issued.
- RUNNING:
  - The tick counter increments every cycle.
  - When counter ≥ selected period −1: strobe, and the counter clears.
  - Presses are ignored.
  - `run_switch`=0 → STOPPED; no strobe in the transition cycle, even if the terminal count coincides.
  - `halt`=1 → HALTED with no strobe. This has priority over `run_switch`.
- HALTED:
  - No strobes; presses and switches are ignored.
  - Exit only via `reset`, which returns to STOPPED.
- `step_count` increments on every strobe and wraps 255→0.
- `cpu_enable` is never high on two consecutive cycles.

## Timing
- Reset values: `cpu_enable`=0, `running`=0, `halted`=0, `step_count`=0. Synchronizer, debounced level, debounce counter and tick counter are all 0.
- Reset asserted mid-run clears everything on the next edge. Any strobe pending for that edge is suppressed.
- Step latency:
  - Let edge 1 be the first edge sampling `step_button`=1, with the input held stable.
  - `cpu_enable` is high in the cycle after edge `DEBOUNCE`+3.
  - Release needs `DEBOUNCE` stable-low cycles before the next press can register.
- Run latency:
  - Let edge E be the edge that enters RUNNING.
  - The first strobe is high in the cycle after edge E+P, where P is the selected period.
  - Subsequent strobes come exactly every P cycles.
- Rate change mid-run: the comparison uses ≥.
  - Switching to fast while counter ≥ `TICKS_FAST`-1 strobes on the next cycle.
  - Switching to slow extends the current period.
- `halt`, `run_switch` and `fast_switch` are sampled directly with no synchronizer. The integration supplies them synchronous to `clock`.
- `running` and `halted` are registered and reflect the state in the same cycle as the state register.

## Test plan
Bench parameters: `DEBOUNCE`=4, `TICKS_SLOW`=10, `TICKS_FAST`=3.

- Clean step press in STOPPED:
  - Stimulus: `step_button` held high from edge 1.
  - Required: exactly one `cpu_enable` pulse, in the cycle after edge 7; `step_count`=1.
- Bounce rejection:
  - Stimulus: toggle `step_button` 1,0,1,0,1 every 2 cycles, then hold high.
  - Required: exactly one strobe, 7 edges after the final rise.
- Free run slow, then fast:
  - Stimulus: `run_switch`=1 for 35 cycles after entry.
  - Required: strobes at entry+10, +20, +30.
  - Then set `fast_switch`=1 at counter=5; required: a strobe on the next cycle, then every 3 cycles.
- Stop on the terminal-count cycle:
  - Stimulus: `run_switch`→0 exactly on the cycle the counter reaches 9.
  - Required: no strobe, state STOPPED, `step_count` unchanged.
- Halt priority and stickiness:
  - Stimulus: `halt`=1 together with a press while RUNNING; then drop `halt` and `run_switch`, and press again.
  - Required: `halted`=1, `running`=0, no strobes at any point.
  - Then `reset`: required `halted`=0 and STOPPED.
- Wrap and mid-run reset:
  - Stimulus: 256 strobes in fast run, then `reset` asserted one cycle before a due strobe.
  - Required: `step_count` goes 255→0 at the 256th strobe; no strobe after the reset edge; all outputs 0.
